gs_test_sequencer: RTL and testbench

GS_TEST_SEQUENCER -- requirements
Module: gs_test_sequencer

---
 rtl/gs_test_sequencer.sv | 169 ++++++++++++++++
 tb/tb_gs_test_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gs_test_sequencer.sv
// Start-test sequencer: fetches one command, fires the acoustic stimulus pulse,
// then streams N ADC samples into the raw-signal FIFO and flags end-of-file.
module gs_test_sequencer #(
    parameter int CNT_W = 16,
    parameter int PW_W  = 8
) (
    input  logic             bus_clk,
    input  logic             bus_rst_n,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_empty,
    output logic             cmd_rden,
    input  logic             raw_open,
    input  logic [15:0]      adc_data,
    input  logic             adc_valid,
    output logic [15:0]      smp_data,
    output logic             smp_wren,
    input  logic             smp_full,
    output logic             raw_eof,
    output logic             stim_pulse,
    output logic             busy,
    output logic             overrun,
    output logic             bad_cmd,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_STIM  = 3'd2,
        ST_ACQ   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PW_W-1:0]  PW_ONE  = {{(PW_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_n;
    logic [PW_W-1:0]   r_pw;
    logic [PW_W-1:0]   r_pw_cnt;
    logic [CNT_W-1:0]  r_sample_cnt;
    logic              r_overrun;
    logic              r_bad_cmd;
    logic              r_raw_eof;

    logic [3:0]        w_opcode;
    logic [CNT_W-1:0]  w_cmd_n;
    logic [PW_W-1:0]   w_cmd_pw;
    logic              w_cmd_ok;
    logic              w_last;
    logic              w_cmd_rden;
    logic              w_stim;
    logic              w_wren;
    logic              w_unused;

    assign w_opcode = cmd_data[31:28];
    assign w_cmd_n  = cmd_data[CNT_W-1:0];
    assign w_cmd_pw = cmd_data[16+PW_W-1:16];
    assign w_cmd_ok = (w_opcode == 4'h1) && (w_cmd_n != '0) && (w_cmd_pw != '0);
    assign w_last   = ((r_sample_cnt + CNT_ONE) == r_n);
    assign w_unused = ^cmd_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rden  = 1'b0;
        w_stim      = 1'b0;
        w_wren      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!cmd_empty && raw_open) begin
                    w_cmd_rden  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = w_cmd_ok ? ST_STIM : ST_IDLE;
            end
            ST_STIM: begin
                if (!raw_open) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stim = 1'b1;
                    if ((r_pw_cnt + PW_ONE) == r_pw) begin
                        w_state_nxt = ST_ACQ;
                    end
                end
            end
            ST_ACQ: begin
                // Abort has priority so nothing lands in the FIFO once the file closes.
                if (!raw_open) begin
                    w_state_nxt = ST_IDLE;
                end else if (adc_valid && smp_full) begin
                    w_state_nxt = ST_DONE;
                end else if (adc_valid) begin
                    w_wren = 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            r_state      <= ST_IDLE;
            r_pw_cnt     <= '0;
            r_sample_cnt <= '0;
            r_overrun    <= 1'b0;
            r_bad_cmd    <= 1'b0;
            r_raw_eof    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_FETCH) begin
                if (w_cmd_ok) begin
                    r_pw_cnt     <= '0;
                    r_sample_cnt <= '0;
                    r_overrun    <= 1'b0;
                    r_bad_cmd    <= 1'b0;
                end else begin
                    r_bad_cmd <= 1'b1;
                end
            end
            if (r_state == ST_STIM) begin
                r_pw_cnt <= r_pw_cnt + PW_ONE;
            end
            if (w_wren) begin
                r_sample_cnt <= r_sample_cnt + CNT_ONE;
            end
            if ((r_state == ST_ACQ) && raw_open && adc_valid && smp_full) begin
                r_overrun <= 1'b1;
            end
            // EOF is dropped whenever the reader closes the file, otherwise it
            // holds from DONE until the next accepted START.
            if (!raw_open) begin
                r_raw_eof <= 1'b0;
            end else if ((r_state == ST_FETCH) && w_cmd_ok) begin
                r_raw_eof <= 1'b0;
            end else if (r_state == ST_DONE) begin
                r_raw_eof <= 1'b1;
            end
        end
    end

    always_ff @(posedge bus_clk) begin
        if ((r_state == ST_FETCH) && w_cmd_ok) begin
            r_n  <= w_cmd_n;
            r_pw <= w_cmd_pw;
        end
    end

    assign cmd_rden   = w_cmd_rden & bus_rst_n;
    assign stim_pulse = w_stim & bus_rst_n;
    assign smp_wren   = w_wren & bus_rst_n;
    assign smp_data   = adc_data;
    assign busy       = (r_state != ST_IDLE) & bus_rst_n;
    assign overrun    = r_overrun;
    assign bad_cmd    = r_bad_cmd;
    assign raw_eof    = r_raw_eof;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_gs_test_sequencer.sv
// Directed + randomized bench for gs_test_sequencer; expected sample streams
// come from a transaction-level model of each run.
module tb_gs_test_sequencer;

    logic        bus_clk;
    logic        bus_rst_n;
    logic [31:0] cmd_data;
    logic        cmd_empty;
    logic        cmd_rden;
    logic        raw_open;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [15:0] smp_data;
    logic        smp_wren;
    logic        smp_full;
    logic        raw_eof;
    logic        stim_pulse;
    logic        busy;
    logic        overrun;
    logic        bad_cmd;
    logic [15:0] sample_cnt;

    int checks = 0;
    int errors = 0;

    gs_test_sequencer #(.CNT_W(16), .PW_W(8)) dut (
        .bus_clk    (bus_clk),
        .bus_rst_n  (bus_rst_n),
        .cmd_data   (cmd_data),
        .cmd_empty  (cmd_empty),
        .cmd_rden   (cmd_rden),
        .raw_open   (raw_open),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .smp_data   (smp_data),
        .smp_wren   (smp_wren),
        .smp_full   (smp_full),
        .raw_eof    (raw_eof),
        .stim_pulse (stim_pulse),
        .busy       (busy),
        .overrun    (overrun),
        .bad_cmd    (bad_cmd),
        .sample_cnt (sample_cnt)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    // Command FIFO: first-word-fall-through is not used; data follows the read strobe.
    logic [31:0] cmd_mem [0:7];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign cmd_empty = (wr_ptr == rd_ptr);
    initial cmd_data = 32'h0;
    always @(posedge bus_clk) begin
        if (cmd_rden) begin
            cmd_data <= cmd_mem[rd_ptr % 8];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Mid-cycle monitor of DUT activity.
    int          stim_cyc = 0;
    int          wr_cnt = 0;
    int          rden_cnt = 0;
    int          rden_busy = 0;
    logic        last_rden_eof = 1'b0;
    logic [15:0] wr_log [0:1023];
    always @(negedge bus_clk) begin
        if (stim_pulse) stim_cyc <= stim_cyc + 1;
        if (smp_wren) begin
            wr_log[wr_cnt % 1024] <= smp_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (cmd_rden) begin
            rden_cnt      <= rden_cnt + 1;
            last_rden_eof <= raw_eof;
            if (busy) rden_busy <= rden_busy + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] w);
        cmd_mem[wr_ptr % 8] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_stim(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick;
            if (stim_pulse) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One START run. Model: strobes k=1..N+2 arrive in ACQ; strobe full_at is
    // lost and ends the run with overrun; otherwise samples are written until N
    // (or until the file is closed after abort_after samples).
    task automatic do_run(input string tag, input int n, input int pw, input int gap,
                          input int full_at, input int abort_after);
        logic [15:0] d[$];
        logic [15:0] e[$];
        bit ended, exp_ovr, exp_eof, ok;
        int nstr, base_w, base_s;
        nstr = n + 2;
        for (int k = 0; k < nstr; k++) d.push_back(16'($urandom));
        ended = 0; exp_ovr = 0; exp_eof = 1;
        for (int k = 1; k <= nstr; k++) begin
            if (!ended) begin
                if (k == full_at) begin
                    exp_ovr = 1; ended = 1;
                end else begin
                    e.push_back(d[k-1]);
                    if (e.size() == n) ended = 1;
                    if (abort_after != 0 && e.size() == abort_after) begin
                        ended = 1; exp_eof = 0;
                    end
                end
            end
        end
        base_w = wr_cnt;
        base_s = stim_cyc;
        push_cmd(32'h1000_0000 | (32'(pw) << 16) | 32'(n));
        wait_stim(20, ok);
        chk({tag, "_stim_start"}, 32'(ok), 32'd1);
        adc_valid = 1'b1;
        adc_data  = 16'($urandom);
        for (int i = 0; i < pw + 5; i++) begin
            tick;
            adc_valid = 1'b0;
            if (!stim_pulse) break;
        end
        for (int k = 1; k <= nstr; k++) begin
            adc_valid = 1'b1;
            adc_data  = d[k-1];
            smp_full  = (k == full_at);
            tick;
            adc_valid = 1'b0;
            smp_full  = 1'b0;
            if (abort_after != 0 && k == abort_after) begin
                raw_open = 1'b0;
                tick;
                chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
                chk({tag, "_abort_eof"}, 32'(raw_eof), 32'd0);
                tick;
                tick;
                raw_open = 1'b1;
            end
            repeat (gap - 1) tick;
        end
        repeat (4) tick;
        chk({tag, "_nwrites"}, 32'(wr_cnt - base_w), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            chk({tag, "_data"}, 32'(wr_log[(base_w + i) % 1024]), 32'(e[i]));
        chk({tag, "_stim_cycles"}, 32'(stim_cyc - base_s), 32'(pw));
        chk({tag, "_sample_cnt"}, 32'(sample_cnt), 32'(e.size()));
        chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
        chk({tag, "_raw_eof"}, 32'(raw_eof), 32'(exp_eof));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bad_cmd"}, 32'(bad_cmd), 32'd0);
    endtask

    initial begin
        int base_r, base_s, base_w, n, pw, gap, fa;
        bit ok, seen;
        bus_rst_n = 1'b0;
        raw_open  = 1'b0;
        adc_data  = 16'h0;
        adc_valid = 1'b0;
        smp_full  = 1'b0;
        repeat (3) tick;

        chk("rst_cmd_rden", 32'(cmd_rden), 32'd0);
        chk("rst_smp_wren", 32'(smp_wren), 32'd0);
        chk("rst_stim", 32'(stim_pulse), 32'd0);
        chk("rst_raw_eof", 32'(raw_eof), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_bad_cmd", 32'(bad_cmd), 32'd0);
        chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        bus_rst_n = 1'b1;
        tick;

        // No fetch while the device file is closed.
        base_r = rden_cnt;
        push_cmd(32'h2003_0004);
        repeat (5) tick;
        chk("closed_no_rden", 32'(rden_cnt - base_r), 32'd0);
        raw_open = 1'b1;
        repeat (5) tick;
        chk("open_rden", 32'(rden_cnt - base_r), 32'd1);
        chk("open_bad_cmd", 32'(bad_cmd), 32'd1);

        do_run("normal", 4, 3, 5, 0, 0);

        // Invalid opcode, PW=0 and N=0 are all consumed and flagged.
        base_r = rden_cnt;
        base_s = stim_cyc;
        push_cmd((32'($urandom_range(2, 15)) << 28) | 32'h0003_0004);
        push_cmd(32'h1000_0004);
        push_cmd(32'h1003_0000);
        repeat (12) tick;
        chk("inv_rden", 32'(rden_cnt - base_r), 32'd3);
        chk("inv_bad_cmd", 32'(bad_cmd), 32'd1);
        chk("inv_no_stim", 32'(stim_cyc - base_s), 32'd0);
        chk("inv_eof_held", 32'(raw_eof), 32'd1);
        chk("inv_cnt_held", 32'(sample_cnt), 32'd4);
        chk("inv_busy", 32'(busy), 32'd0);

        raw_open = 1'b0;
        tick;
        chk("close_clears_eof", 32'(raw_eof), 32'd0);
        raw_open = 1'b1;
        tick;

        do_run("overrun", 4, 3, 5, 3, 0);
        do_run("abort", 6, 2, 3, 0, 2);
        do_run("min_n_pw", 1, 1, 1, 0, 0);
        do_run("full_first", 3, 1, 1, 1, 0);
        for (int r = 0; r < 6; r++) begin
            n   = $urandom_range(1, 8);
            pw  = $urandom_range(1, 6);
            gap = $urandom_range(1, 4);
            fa  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            do_run("rand", n, pw, gap, fa, 0);
        end

        // Back-to-back: second START waits for DONE; its FETCH clears EOF.
        base_r = rden_cnt;
        base_s = stim_cyc;
        base_w = wr_cnt;
        seen   = 1'b0;
        push_cmd(32'h1002_0002);
        push_cmd(32'h1001_0003);
        for (int i = 0; i < 200; i++) begin
            adc_valid = 1'b1;
            adc_data  = 16'($urandom);
            tick;
            if ((rden_cnt - base_r) == 2 && stim_pulse && !seen) begin
                chk("b2b_eof_cleared", 32'(raw_eof), 32'd0);
                seen = 1'b1;
            end
            if (seen && !busy) break;
        end
        adc_valid = 1'b0;
        repeat (3) tick;
        chk("b2b_second_started", 32'(seen), 32'd1);
        chk("b2b_eof_at_2nd_rden", 32'(last_rden_eof), 32'd1);
        chk("b2b_rden", 32'(rden_cnt - base_r), 32'd2);
        chk("b2b_writes", 32'(wr_cnt - base_w), 32'd5);
        chk("b2b_stim_cycles", 32'(stim_cyc - base_s), 32'd3);
        chk("b2b_sample_cnt", 32'(sample_cnt), 32'd3);
        chk("b2b_raw_eof", 32'(raw_eof), 32'd1);
        chk("rden_never_busy", 32'(rden_busy), 32'd0);

        // Reset in the middle of a long stimulus pulse.
        push_cmd(32'h100A_0005);
        wait_stim(20, ok);
        chk("rstmid_stim_start", 32'(ok), 32'd1);
        tick;
        tick;
        bus_rst_n = 1'b0;
        tick;
        chk("rstmid_stim", 32'(stim_pulse), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_cmd_rden", 32'(cmd_rden), 32'd0);
        chk("rstmid_smp_wren", 32'(smp_wren), 32'd0);
        chk("rstmid_raw_eof", 32'(raw_eof), 32'd0);
        chk("rstmid_overrun", 32'(overrun), 32'd0);
        chk("rstmid_bad_cmd", 32'(bad_cmd), 32'd0);
        chk("rstmid_sample_cnt", 32'(sample_cnt), 32'd0);
        bus_rst_n = 1'b1;
        base_s = stim_cyc;
        repeat (6) tick;
        chk("rstmid_after_busy", 32'(busy), 32'd0);
        chk("rstmid_after_eof", 32'(raw_eof), 32'd0);
        chk("rstmid_after_stim", 32'(stim_cyc - base_s), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
